// File: rtl/cbp_decode_pipe_if.sv
// ----------------------------------------------------------------------------
// cbp_decode_pipe_if
//   Handshake bundle between the slice-data parser (master) and the
//   coded_block_pattern decode pipe (slave).
//
//   Request side  : in_valid/in_ready plus the per-macroblock fields
//                   (kind, intra, ChromaArrayType, codeNum, mb_type, mb_x,
//                   left/top availability).
//   Result side   : out_valid/out_ready plus CBP luma/chroma, neighbour CBPs,
//                   registered availability flags and the error flag.
// ----------------------------------------------------------------------------
interface cbp_decode_pipe_if #(
    parameter int MBX_W = 7
);
    // Request channel
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_kind;
    logic             in_intra;
    logic [1:0]       in_cat;
    logic [5:0]       in_code;
    logic [4:0]       in_mb_type;
    logic [MBX_W-1:0] in_mb_x;
    logic             in_left_avail;
    logic             in_top_avail;

    // Result channel
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       cbp_luma;
    logic [1:0]       cbp_chroma;
    logic [5:0]       cbp_left;
    logic [5:0]       cbp_top;
    logic             left_valid;
    logic             top_valid;
    logic             err;

    // Producer of transactions / consumer of results.
    modport master (
        output in_valid, in_kind, in_intra, in_cat, in_code, in_mb_type,
               in_mb_x, in_left_avail, in_top_avail, out_ready,
        input  in_ready, out_valid, cbp_luma, cbp_chroma, cbp_left, cbp_top,
               left_valid, top_valid, err
    );

    // The decode pipe itself.
    modport slave (
        input  in_valid, in_kind, in_intra, in_cat, in_code, in_mb_type,
               in_mb_x, in_left_avail, in_top_avail, out_ready,
        output in_ready, out_valid, cbp_luma, cbp_chroma, cbp_left, cbp_top,
               left_valid, top_valid, err
    );
endinterface

// File: rtl/cbp_decode_pipe.sv
// ----------------------------------------------------------------------------
// cbp_decode_pipe
//   One-stage registered coded_block_pattern decoder for the slice-data path.
//   Each accepted macroblock transaction yields CodedBlockPatternLuma/Chroma
//   one cycle later, together with the CBPs of the left and top neighbours
//   taken from a small left register and a per-column top-row store.
//
//   Ports
//     clk    : clock
//     reset  : synchronous, active-high reset
//     bus    : cbp_decode_pipe_if.slave
//              in_valid/in_ready     request handshake
//              in_kind               0=me(v) codeNum, 1=Intra16x16, 2=skip, 3=I_PCM
//              in_intra              kind 0 column select (1=Intra4x4/8x8, 0=Inter)
//              in_cat                ChromaArrayType
//              in_code               codeNum (kind 0)
//              in_mb_type            I-slice mb_type 1..24 (kind 1)
//              in_mb_x               macroblock column
//              in_left/top_avail     neighbour availability within the slice
//              out_valid/out_ready   result handshake
//              cbp_luma/cbp_chroma   decoded CBP of the current macroblock
//              cbp_left/cbp_top      {chroma,luma} of neighbours, 0 if unavailable
//              left_valid/top_valid  registered availability flags
//              err                   illegal input in this transaction
// ----------------------------------------------------------------------------
module cbp_decode_pipe #(
    parameter int MAX_MB_W = 120,
    parameter int MBX_W    = 7
) (
    input  logic               clk,
    input  logic               reset,
    cbp_decode_pipe_if.slave   bus
);

    // ------------------------------------------------------------------
    // me(v) mapping, ChromaArrayType 1 or 2. Returns {intra, inter} CBP.
    // ------------------------------------------------------------------
    function automatic logic [11:0] map_cat12(input logic [5:0] code);
        logic [11:0] pair;
        pair = '0;
        case (code)
            6'd0:  pair = {6'd47, 6'd0};
            6'd1:  pair = {6'd31, 6'd16};
            6'd2:  pair = {6'd15, 6'd1};
            6'd3:  pair = {6'd0,  6'd2};
            6'd4:  pair = {6'd23, 6'd4};
            6'd5:  pair = {6'd27, 6'd8};
            6'd6:  pair = {6'd29, 6'd32};
            6'd7:  pair = {6'd30, 6'd3};
            6'd8:  pair = {6'd7,  6'd5};
            6'd9:  pair = {6'd11, 6'd10};
            6'd10: pair = {6'd13, 6'd12};
            6'd11: pair = {6'd14, 6'd15};
            6'd12: pair = {6'd39, 6'd47};
            6'd13: pair = {6'd43, 6'd7};
            6'd14: pair = {6'd45, 6'd11};
            6'd15: pair = {6'd46, 6'd13};
            6'd16: pair = {6'd16, 6'd14};
            6'd17: pair = {6'd3,  6'd6};
            6'd18: pair = {6'd5,  6'd9};
            6'd19: pair = {6'd10, 6'd31};
            6'd20: pair = {6'd12, 6'd35};
            6'd21: pair = {6'd19, 6'd37};
            6'd22: pair = {6'd21, 6'd42};
            6'd23: pair = {6'd26, 6'd44};
            6'd24: pair = {6'd28, 6'd33};
            6'd25: pair = {6'd35, 6'd34};
            6'd26: pair = {6'd37, 6'd36};
            6'd27: pair = {6'd42, 6'd40};
            6'd28: pair = {6'd44, 6'd39};
            6'd29: pair = {6'd1,  6'd43};
            6'd30: pair = {6'd2,  6'd45};
            6'd31: pair = {6'd4,  6'd46};
            6'd32: pair = {6'd8,  6'd17};
            6'd33: pair = {6'd17, 6'd18};
            6'd34: pair = {6'd18, 6'd20};
            6'd35: pair = {6'd20, 6'd24};
            6'd36: pair = {6'd24, 6'd19};
            6'd37: pair = {6'd6,  6'd21};
            6'd38: pair = {6'd9,  6'd26};
            6'd39: pair = {6'd22, 6'd28};
            6'd40: pair = {6'd25, 6'd23};
            6'd41: pair = {6'd32, 6'd27};
            6'd42: pair = {6'd33, 6'd29};
            6'd43: pair = {6'd34, 6'd30};
            6'd44: pair = {6'd36, 6'd22};
            6'd45: pair = {6'd40, 6'd25};
            6'd46: pair = {6'd38, 6'd38};
            6'd47: pair = {6'd41, 6'd41};
            default: pair = '0;
        endcase
        return pair;
    endfunction

    // ------------------------------------------------------------------
    // me(v) mapping, ChromaArrayType 0 or 3 (luma only). Returns
    // {intra, inter} luma CBP.
    // ------------------------------------------------------------------
    function automatic logic [7:0] map_cat03(input logic [3:0] code);
        logic [7:0] pair;
        pair = '0;
        case (code)
            4'd0:  pair = {4'd15, 4'd0};
            4'd1:  pair = {4'd0,  4'd1};
            4'd2:  pair = {4'd7,  4'd2};
            4'd3:  pair = {4'd11, 4'd4};
            4'd4:  pair = {4'd13, 4'd8};
            4'd5:  pair = {4'd14, 4'd3};
            4'd6:  pair = {4'd3,  4'd5};
            4'd7:  pair = {4'd5,  4'd10};
            4'd8:  pair = {4'd10, 4'd12};
            4'd9:  pair = {4'd12, 4'd15};
            4'd10: pair = {4'd1,  4'd7};
            4'd11: pair = {4'd2,  4'd11};
            4'd12: pair = {4'd4,  4'd13};
            4'd13: pair = {4'd8,  4'd14};
            4'd14: pair = {4'd6,  4'd6};
            4'd15: pair = {4'd9,  4'd9};
            default: pair = '0;
        endcase
        return pair;
    endfunction

    // ------------------------------------------------------------------
    // Decode (combinational, from the request fields)
    // ------------------------------------------------------------------
    logic        w_accept;
    logic        w_col_ok;
    logic        w_has_chroma;
    logic [3:0]  w_luma;
    logic [1:0]  w_chroma;
    logic        w_err_dec;
    logic        w_err;
    logic [5:0]  w_cbp;
    logic [11:0] w_pair12;
    logic [7:0]  w_pair03;
    logic [4:0]  w_mt_m1;
    logic [1:0]  w_i16_chroma;
    logic [5:0]  w_top_rd;

    // Output / state registers
    logic        r_out_valid;
    logic [3:0]  r_luma;
    logic [1:0]  r_chroma;
    logic [5:0]  r_cbp_left;
    logic [5:0]  r_cbp_top;
    logic        r_left_valid;
    logic        r_top_valid;
    logic        r_err;
    logic [5:0]  r_left;
    logic [5:0]  r_top_mem [MAX_MB_W];

    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_col_ok     = int'(bus.in_mb_x) < MAX_MB_W;
    assign w_has_chroma = (bus.in_cat == 2'd1) || (bus.in_cat == 2'd2);
    assign w_pair12     = map_cat12(bus.in_code);
    assign w_pair03     = map_cat03(bus.in_code[3:0]);

    // Intra16x16 chroma repeats 0,1,2 over groups of four mb_types.
    assign w_mt_m1 = bus.in_mb_type - 5'd1;
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        w_i16_chroma = 2'd0;
        case (w_mt_m1[4:2])
            3'd1, 3'd4: w_i16_chroma = 2'd1;
            3'd2, 3'd5: w_i16_chroma = 2'd2;
            default:    w_i16_chroma = 2'd0;
        endcase
    end

    always_comb begin
        w_luma    = 4'd0;
        w_chroma  = 2'd0;
        w_err_dec = 1'b0;
        unique case (bus.in_kind)
            2'd0: begin
                if (w_has_chroma) begin
                    if (bus.in_code > 6'd47) begin
                        w_err_dec = 1'b1;
                    end else if (bus.in_intra) begin
                        {w_chroma, w_luma} = w_pair12[11:6];
                    end else begin
                        {w_chroma, w_luma} = w_pair12[5:0];
                    end
                end else begin
                    if (bus.in_code > 6'd15) begin
                        w_err_dec = 1'b1;
                    end else begin
                        w_luma = bus.in_intra ? w_pair03[7:4] : w_pair03[3:0];
                    end
                end
            end
            2'd1: begin
                if (bus.in_mb_type == 5'd0 || bus.in_mb_type > 5'd24) begin
                    w_err_dec = 1'b1;
                end else begin
                    w_luma = (bus.in_mb_type >= 5'd13) ? 4'd15 : 4'd0;
                    // Monochrome / 4:4:4 streams cannot signal chroma here.
                    if (!w_has_chroma && w_i16_chroma != 2'd0) begin
                        w_err_dec = 1'b1;
                    end else begin
                        w_chroma = w_i16_chroma;
                    end
                end
            end
            2'd2: begin
                w_luma   = 4'd0;
                w_chroma = 2'd0;
            end
            2'd3: begin
                w_luma   = 4'd15;
                w_chroma = 2'd2;
            end
        endcase
    end

    assign w_err    = w_err_dec || !w_col_ok;
    assign w_cbp    = {w_chroma, w_luma};
    assign w_top_rd = w_col_ok ? r_top_mem[bus.in_mb_x] : 6'd0;

    // ------------------------------------------------------------------
    // Output register and left neighbour
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values; the neighbour read-before-write
        // below depends on it.
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_luma       <= 4'd0;
            r_chroma     <= 2'd0;
            r_cbp_left   <= 6'd0;
            r_cbp_top    <= 6'd0;
            r_left_valid <= 1'b0;
            r_top_valid  <= 1'b0;
            r_err        <= 1'b0;
            r_left       <= 6'd0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_luma       <= w_luma;
            r_chroma     <= w_chroma;
            r_cbp_left   <= bus.in_left_avail ? r_left : 6'd0;
            r_cbp_top    <= bus.in_top_avail ? w_top_rd : 6'd0;
            r_left_valid <= bus.in_left_avail;
            r_top_valid  <= bus.in_top_avail;
            r_err        <= w_err;
            r_left       <= w_cbp;
        end else if (bus.out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Top-row store: one entry per macroblock column.
    // ------------------------------------------------------------------
    // NOTE: the store has no reset; stale contents are never observed
    // because every read is gated by in_top_avail, and leaving it
    // unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_accept && !reset && w_col_ok) begin
            r_top_mem[bus.in_mb_x] <= w_cbp;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready   = !r_out_valid || bus.out_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.cbp_luma   = r_luma;
    assign bus.cbp_chroma = r_chroma;
    assign bus.cbp_left   = r_cbp_left;
    assign bus.cbp_top    = r_cbp_top;
    assign bus.left_valid = r_left_valid;
    assign bus.top_valid  = r_top_valid;
    assign bus.err        = r_err;

endmodule

// File: tb/tb_cbp_decode_pipe.sv
// ----------------------------------------------------------------------------
// tb_cbp_decode_pipe
//   Directed self-checking bench for cbp_decode_pipe. Inputs are driven on
//   the falling edge, outputs sampled on the falling edge after the accept.
// ----------------------------------------------------------------------------
module tb_cbp_decode_pipe;
    localparam int MAX_MB_W = 120;
    localparam int MBX_W    = 7;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    typedef struct {
        logic [1:0] kind;
        logic       intra;
        logic [1:0] cat;
        logic [5:0] code;
        logic [4:0] mbt;
        logic [6:0] x;
        logic       la;
        logic       ta;
        logic       err;
        logic [5:0] cbp;
        logic [5:0] left;
        logic [5:0] top;
        string      name;
    } vec_t;

    cbp_decode_pipe_if #(.MBX_W(MBX_W)) bus ();

    cbp_decode_pipe #(.MAX_MB_W(MAX_MB_W), .MBX_W(MBX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [1:0] kind, input logic intra,
                                input logic [1:0] cat, input logic [5:0] code,
                                input logic [4:0] mbt, input logic [6:0] x,
                                input logic la, input logic ta, input logic err,
                                input logic [5:0] cbp, input logic [5:0] left,
                                input logic [5:0] top, input string name);
        vec_t v;
        v.kind = kind; v.intra = intra; v.cat = cat; v.code = code;
        v.mbt = mbt; v.x = x; v.la = la; v.ta = ta; v.err = err;
        v.cbp = cbp; v.left = left; v.top = top; v.name = name;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.in_kind       = v.kind;
        bus.in_intra      = v.intra;
        bus.in_cat        = v.cat;
        bus.in_code       = v.code;
        bus.in_mb_type    = v.mbt;
        bus.in_mb_x       = v.x;
        bus.in_left_avail = v.la;
        bus.in_top_avail  = v.ta;
        bus.in_valid      = 1'b1;
    endtask

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic send(input vec_t v);
        int waited = 0;
        drive(v);
        #1;
        while (!bus.in_ready && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_accept: in_ready low for %0d cycles, required high", v.name, waited);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [25:0] got;
        checks++;
        got = {bus.out_valid, bus.in_ready, bus.cbp_luma, bus.cbp_chroma, bus.cbp_left,
               bus.cbp_top, bus.left_valid, bus.top_valid, bus.err};
        if (got !== 26'b01_0000_00_000000_000000_000) begin
            failures++;
            $display("FAIL reset_state: got %b required %b", got, 26'b01_0000_00_000000_000000_000);
        end
    endtask

    task automatic test_decode();
        vec_t v[$];
        logic [7:0] got, exp;
        v.push_back(mk(0, 1, 1, 0,  0, 0, 0, 0, 0, 6'h2F, 0, 0, "k0_intra_c1_code0"));
        v.push_back(mk(0, 1, 1, 3,  0, 0, 0, 0, 0, 6'h00, 0, 0, "k0_intra_c1_code3"));
        v.push_back(mk(0, 1, 1, 48, 0, 0, 0, 0, 1, 6'h00, 0, 0, "k0_intra_c1_code48"));
        v.push_back(mk(0, 0, 1, 1,  0, 0, 0, 0, 0, 6'h10, 0, 0, "k0_inter_c1_code1"));
        v.push_back(mk(0, 0, 1, 5,  0, 0, 0, 0, 0, 6'h08, 0, 0, "k0_inter_c1_code5"));
        v.push_back(mk(0, 0, 1, 11, 0, 0, 0, 0, 0, 6'h0F, 0, 0, "k0_inter_c1_code11"));
        v.push_back(mk(0, 1, 2, 47, 0, 0, 0, 0, 0, 6'h29, 0, 0, "k0_intra_c2_code47"));
        v.push_back(mk(0, 0, 0, 3,  0, 0, 0, 0, 0, 6'h04, 0, 0, "k0_inter_c0_code3"));
        v.push_back(mk(0, 0, 0, 16, 0, 0, 0, 0, 1, 6'h00, 0, 0, "k0_inter_c0_code16"));
        v.push_back(mk(0, 0, 3, 9,  0, 0, 0, 0, 0, 6'h0F, 0, 0, "k0_inter_c3_code9"));
        v.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0, 0, 6'h0F, 0, 0, "k0_intra_c0_code0"));
        v.push_back(mk(1, 0, 1, 0, 24, 0, 0, 0, 0, 6'h2F, 0, 0, "i16_mbt24"));
        v.push_back(mk(1, 0, 1, 0,  5, 0, 0, 0, 0, 6'h10, 0, 0, "i16_mbt5"));
        v.push_back(mk(1, 0, 3, 0,  5, 0, 0, 0, 1, 6'h00, 0, 0, "i16_mbt5_cat3"));
        v.push_back(mk(1, 0, 1, 0, 13, 0, 0, 0, 0, 6'h0F, 0, 0, "i16_mbt13"));
        v.push_back(mk(1, 0, 0, 0,  1, 0, 0, 0, 0, 6'h00, 0, 0, "i16_mbt1_cat0"));
        v.push_back(mk(1, 0, 1, 0,  0, 0, 0, 0, 1, 6'h00, 0, 0, "i16_mbt0"));
        v.push_back(mk(1, 0, 1, 0, 25, 0, 0, 0, 1, 6'h00, 0, 0, "i16_mbt25"));
        v.push_back(mk(3, 0, 1, 0,  0, 0, 0, 0, 0, 6'h2F, 0, 0, "ipcm"));
        v.push_back(mk(2, 0, 1, 0,  0, 0, 0, 0, 0, 6'h00, 0, 0, "skip"));
        bus.out_ready = 1'b1;
        foreach (v[i]) begin
            send(v[i]);
            got = {bus.out_valid, bus.err, bus.cbp_chroma, bus.cbp_luma};
            exp = {1'b1, v[i].err, v[i].cbp};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL %s: got valid/err/cbp=%b required %b", v[i].name, got, exp);
            end
        end
    endtask

    task automatic test_neighbours();
        vec_t v[$];
        logic [20:0] got, exp;
        v.push_back(mk(3, 0, 1, 0,  0,   0, 0, 0, 0, 6'h2F, 6'h00, 6'h00, "nb_r0_x0"));
        v.push_back(mk(0, 0, 1, 32, 0,   1, 1, 0, 0, 6'h11, 6'h2F, 6'h00, "nb_r0_x1"));
        v.push_back(mk(2, 0, 1, 0,  0,   0, 1, 1, 0, 6'h00, 6'h11, 6'h2F, "nb_r1_x0"));
        v.push_back(mk(1, 0, 1, 0,  24,  1, 0, 1, 0, 6'h2F, 6'h00, 6'h11, "nb_r1_x1_noleft"));
        v.push_back(mk(2, 0, 1, 0,  0,   1, 1, 1, 0, 6'h00, 6'h2F, 6'h2F, "nb_r2_x1"));
        v.push_back(mk(3, 0, 1, 0,  0, 120, 1, 1, 1, 6'h2F, 6'h00, 6'h00, "nb_x_out_of_range"));
        v.push_back(mk(2, 0, 1, 0,  0,   0, 1, 1, 0, 6'h00, 6'h2F, 6'h00, "nb_after_oor"));
        bus.out_ready = 1'b1;
        foreach (v[i]) begin
            send(v[i]);
            got = {bus.left_valid, bus.top_valid, bus.err, bus.cbp_chroma, bus.cbp_luma,
                   bus.cbp_left, bus.cbp_top};
            exp = {v[i].la, v[i].ta, v[i].err, v[i].cbp, v[i].left, v[i].top};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL %s: got lv/tv/err/cbp/left/top=%b required %b", v[i].name, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t a, b, c;
        logic [8:0] got;
        a = mk(3, 0, 1, 0, 0, 5, 0, 0, 0, 6'h2F, 0, 0, "bp_a");
        b = mk(0, 0, 1, 1, 0, 6, 0, 0, 0, 6'h10, 0, 0, "bp_b");
        c = mk(0, 0, 1, 5, 0, 7, 0, 0, 0, 6'h08, 0, 0, "bp_c");
        drain();
        bus.out_ready = 1'b0;
        drive(a);
        @(posedge clk);
        @(negedge clk);
        drive(b);
        #1;
        checks++;
        got = {bus.in_ready, bus.out_valid, bus.err, bus.cbp_chroma, bus.cbp_luma};
        if (got !== {2'b01, 1'b0, 6'h2F}) begin
            failures++;
            $display("FAIL bp_first: got rdy/valid/err/cbp=%b required %b", got, {2'b01, 1'b0, 6'h2F});
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            checks++;
            got = {bus.in_ready, bus.out_valid, bus.err, bus.cbp_chroma, bus.cbp_luma};
            if (got !== {2'b01, 1'b0, 6'h2F}) begin
                failures++;
                $display("FAIL bp_hold_%0d: got rdy/valid/err/cbp=%b required %b", k, got, {2'b01, 1'b0, 6'h2F});
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        got = {1'b0, bus.out_valid, bus.err, bus.cbp_chroma, bus.cbp_luma};
        if (got !== {2'b01, 1'b0, 6'h10}) begin
            failures++;
            $display("FAIL bp_second: got valid/err/cbp=%b required %b", got, {2'b01, 1'b0, 6'h10});
        end
        drive(c);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        got = {1'b0, bus.out_valid, bus.err, bus.cbp_chroma, bus.cbp_luma};
        if (got !== {2'b01, 1'b0, 6'h08}) begin
            failures++;
            $display("FAIL bp_third: got valid/err/cbp=%b required %b", got, {2'b01, 1'b0, 6'h08});
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_no_dup: got out_valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        vec_t d, e;
        logic [15:0] got;
        d = mk(3, 0, 1, 0, 0, 2, 0, 0, 0, 6'h2F, 0, 0, "rst_pending");
        e = mk(2, 0, 1, 0, 0, 0, 1, 0, 0, 6'h00, 6'h00, 6'h00, "rst_after");
        drain();
        bus.out_ready = 1'b0;
        send(d);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_pending_valid: got out_valid=%b required 1", bus.out_valid);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL rst_midstream: got valid/ready=%b required 01", {bus.out_valid, bus.in_ready});
        end
        reset = 1'b0;
        bus.out_ready = 1'b1;
        send(e);
        checks++;
        got = {bus.out_valid, bus.left_valid, bus.err, bus.cbp_chroma, bus.cbp_luma, bus.cbp_left, 1'b0};
        if (got !== {3'b110, 6'h00, 6'h00, 1'b0}) begin
            failures++;
            $display("FAIL rst_left_cleared: got valid/lv/err/cbp/left=%b required %b",
                     got, {3'b110, 6'h00, 6'h00, 1'b0});
        end
    endtask

    initial begin
        reset             = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_kind       = '0;
        bus.in_intra      = 1'b0;
        bus.in_cat        = '0;
        bus.in_code       = '0;
        bus.in_mb_type    = '0;
        bus.in_mb_x       = '0;
        bus.in_left_avail = 1'b0;
        bus.in_top_avail  = 1'b0;
        bus.out_ready     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;

        test_reset();
        @(negedge clk);
        test_decode();
        test_neighbours();
        test_back_to_back();
        test_reset_midstream();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
